// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: instruction width, bubble encoding, opcodes, immediate field bounds
package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_B   = 6'b000101;
  localparam logic [7:0] OP_CBZ = 8'b10110100;
  localparam logic [7:0] OP_BLT = 8'b01010100;

  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

endpackage

// File: rtl/br_target_calc.sv
// rtl/br_target_calc.sv - combinational branch target: id_pc + (sext(imm26 or imm19) << 2)
module br_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  id_pc,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               uncond_br,
  output logic [ADDR_W-1:0]  tgt
);

  logic [ADDR_W-1:0] off_ext;
  logic              unused_instr_bits;

  // Opcode and Rt bits do not affect the target.
  assign unused_instr_bits = ^{id_instr[INSTR_W-1:IMM26_MSB+1], id_instr[IMM19_LSB-1:0]};

  always_comb begin
    off_ext = '0;
    if (uncond_br) begin
      off_ext = {{(ADDR_W-IMM26_W){id_instr[IMM26_MSB]}}, id_instr[IMM26_MSB:IMM26_LSB]};
    end else begin
      off_ext = {{(ADDR_W-IMM19_W){id_instr[IMM19_MSB]}}, id_instr[IMM19_MSB:IMM19_LSB]};
    end
  end

  assign tgt = id_pc + (off_ext << 2);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC register, next-PC mux and IF/ID pipeline register
module if_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W     = 64,
  parameter bit                 DELAY_SLOT = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               uncond_br,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  tgt;

  br_target_calc #(.ADDR_W(ADDR_W)) u_br_target_calc (
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .uncond_br (uncond_br),
    .tgt       (tgt)
  );

  // A stalled branch stays in ID and re-asserts br_taken, so it is simply ignored here.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    if (!stall) begin
      pc_d   = br_taken ? tgt : pc_q + ADDR_W'(4);
      ifpc_d = pc_q;
      if (br_taken && !DELAY_SLOT) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage, delay-slot and flush configurations side by side
module tb_if_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, uncond_br;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  logic [63:0] addr1, addr0, pc1, pc0;
  logic [31:0] rd1, rd0, ins1, ins0;
  logic        v1, v0;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [31:0] m_i1, m_i0;
  logic [63:0] m_p1, m_p0;
  logic        m_v1, m_v0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0] ^ {a[63:48], 16'h0};
  endfunction

  assign rd1 = imem(addr1);
  assign rd0 = imem(addr0);

  if_stage #(.ADDR_W(64), .DELAY_SLOT(1'b1), .NOP_INSTR(32'h0)) u_ds1 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br),
    .id_instr(id_instr), .id_pc(id_pc), .imem_addr(addr1), .imem_rdata(rd1),
    .if_id_instr(ins1), .if_id_pc(pc1), .if_id_valid(v1)
  );

  if_stage #(.ADDR_W(64), .DELAY_SLOT(1'b0), .NOP_INSTR(32'h0)) u_ds0 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br),
    .id_instr(id_instr), .id_pc(id_pc), .imem_addr(addr0), .imem_rdata(rd0),
    .if_id_instr(ins0), .if_id_pc(pc0), .if_id_valid(v0)
  );

  function automatic logic [63:0] model_tgt(input logic unc, input logic [31:0] ins,
                                            input logic [63:0] ipc);
    longint o;
    if (unc) begin
      o = longint'(ins[25:0]);
      if (o >= 64'sd33554432) o = o - 64'sd67108864;
    end else begin
      o = longint'(ins[23:5]);
      if (o >= 64'sd262144) o = o - 64'sd524288;
    end
    return ipc + 64'(o * 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic br, input logic unc,
                       input logic [31:0] ins, input logic [63:0] ipc);
    logic [31:0] fetched;
    reset = rst; stall = st; br_taken = br; uncond_br = unc; id_instr = ins; id_pc = ipc;
    fetched = imem(m_pc);
    if (rst) begin
      m_pc = 64'h0;
      m_i1 = 32'h0; m_p1 = 64'h0; m_v1 = 1'b0;
      m_i0 = 32'h0; m_p0 = 64'h0; m_v0 = 1'b0;
    end else if (!st) begin
      m_i1 = fetched; m_p1 = m_pc; m_v1 = 1'b1;
      m_p0 = m_pc;
      if (br) begin
        m_i0 = 32'h0; m_v0 = 1'b0;
      end else begin
        m_i0 = fetched; m_v0 = 1'b1;
      end
      m_pc = br ? model_tgt(unc, ins, ipc) : m_pc + 64'd4;
    end
    @(posedge clk);
    #1;
    chk("addr_ds1", addr1, m_pc);
    chk("addr_ds0", addr0, m_pc);
    chk("instr_ds1", 64'(ins1), 64'(m_i1));
    chk("pc_ds1", pc1, m_p1);
    chk("valid_ds1", 64'(v1), 64'(m_v1));
    chk("instr_ds0", 64'(ins0), 64'(m_i0));
    chk("pc_ds0", pc0, m_p0);
    chk("valid_ds0", 64'(v0), 64'(m_v0));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ri;
    m_pc = '0; m_i1 = '0; m_p1 = '0; m_v1 = 1'b0; m_i0 = '0; m_p0 = '0; m_v0 = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("rst_valid", 64'(v1), 64'h0);
    chk("rst_addr", addr1, 64'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
      chk("seq_pc", pc1, 64'(k * 4));
      chk("seq_valid", 64'(v1), 64'h1);
    end

    cycle(1'b0, 1'b0, 1'b1, 1'b1, {OP_B, 26'h11}, 64'h0);
    chk("br_to_44", addr1, 64'h44);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, {OP_B, 26'h3FFFFFC}, 64'h40);
    chk("b_neg_tgt", addr1, 64'h30);
    chk("slot_pc_ds1", pc1, 64'h44);
    chk("slot_valid_ds1", 64'(v1), 64'h1);
    chk("flush_valid_ds0", 64'(v0), 64'h0);
    chk("flush_instr_ds0", 64'(ins0), 64'h0);

    cycle(1'b0, 1'b0, 1'b1, 1'b0, {OP_CBZ, 19'd3, 5'd0}, 64'h20);
    chk("cbz_pos", addr1, 64'h2C);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, {OP_CBZ, 19'h7FFFF, 5'd7}, 64'h20);
    chk("cbz_neg", addr1, 64'h1C);

    cycle(1'b0, 1'b0, 1'b1, 1'b1, {OP_B, 26'd4}, 64'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
      chk("stall_addr", addr1, 64'h10);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("resume_addr", addr1, 64'h14);
    chk("resume_pc", pc1, 64'h10);

    cycle(1'b0, 1'b1, 1'b1, 1'b1, {OP_B, 26'h100}, 64'h0);
    chk("stall_br_hold", addr1, 64'h14);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, {OP_B, 26'h100}, 64'h0);
    chk("br_after_stall", addr1, 64'h400);

    cycle(1'b0, 1'b0, 1'b1, 1'b1, {OP_B, 26'h3FFFFFF}, 64'h0);
    chk("to_top", addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("wrap", addr1, 64'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, {OP_B, 26'h20}, 64'h0);
    chk("rst_br_addr", addr1, 64'h0);
    chk("rst_br_valid", 64'(v1), 64'h0);

    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            1'($urandom_range(0, 1)), ri, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
